// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/subtract unit: adds two WIDTH-bit operands CHUNK bits per clock
// through a single carry register, with valid/ready handshakes on both sides.
module chunk_serial_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NCH - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // holds ~b for subtraction
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_chunk;

    // One chunk-wide slice of the adder, selected by the chunk index.
    always_comb begin
        a_chunk = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk = b_q[idx_q*CHUNK +: CHUNK];
        {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state logic: accept in IDLE, one chunk per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;  // subtraction is a + ~b + 1
                    idx_d   = '0;
                end
            end
            StRun: begin
                sum_d[idx_q*CHUNK +: CHUNK] = s_chunk;
                carry_d = c_chunk;
                if (idx_q == LastIdx) begin
                    cout_d  = c_chunk;
                    // The last chunk carries the MSB, so s_chunk's top bit is sum[MSB].
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (s_chunk[CHUNK-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
